uart_tx_fifo: RTL

Transmit byte queue that sits directly upstream of the UART transmitter (sender) in the memory-mapped UART peripheral. The CPU-side write path pushes bytes into it at bus speed. The block drains them one at a time into the transmitter using the transmitter's TX_EN / TX_STATUS handshake. Software no longer has to poll TX_STATUS before every byte.

---
 rtl/uart_tx_fifo.sv | 96 +++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit byte queue feeding the UART sender: circular buffer plus a launch FSM
// that hands bytes over using the transmitter's tx_en / tx_status handshake.
module uart_tx_fifo #(
   parameter int DEPTH  = 16,
   parameter int PTR_W  = 4,
   parameter int DATA_W = 8
) (
   input  logic              CLK,
   input  logic              Reset_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              clear,
   input  logic              tx_status,
   output logic              tx_en,
   output logic [DATA_W-1:0] tx_data,
   output logic              full,
   output logic              empty,
   output logic [PTR_W:0]    level,
   output logic              overflow
);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic              pop;
   logic              wr_ok;

   assign level = count;
   assign full  = (count == (PTR_W+1)'(DEPTH));
   assign empty = (count == '0);

   // clear wins over a launch in the same cycle, so the pop is gated here
   assign pop   = (state == IDLE) && !empty && tx_status && !clear;
   assign wr_ok = push && !clear && (!full || pop);

   always_ff @(posedge CLK) begin
      if (wr_ok)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (wr_ok && !pop)
            count <= count + 1'b1;
         else if (pop && !wr_ok)
            count <= count - 1'b1;
         if (push && full && !pop)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state   <= IDLE;
         tx_en   <= 1'b0;
         tx_data <= '0;
      end else begin
         tx_en <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  tx_data <= mem[rd_ptr];
                  tx_en   <= 1'b1;
                  state   <= LAUNCH;
               end
            end
            LAUNCH:    state <= WAIT_BUSY;
            WAIT_BUSY: if (!tx_status) state <= WAIT_DONE;
            WAIT_DONE: if (tx_status) state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

endmodule
